wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 5-stage MIPS core.
- Consumes the control, PC and instruction fields leaving the MEM/WB pipeline register, together with the ALU result and memory read data for the same instruction.
- Selects the destination register, formats load data and writes the 32x32 register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass.

Parameters:
- PC_W, 9, width of WB_pc_4; zero-extended to 32 bits on link writes.
- REG_N, 32, number of architectural registers (5-bit addresses).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- WB_memtoreg  in  1  write data comes from formatted memory read data.
- WB_regwrite  in  1  instruction writes a register.
- WB_regdst  in  1  1: destination rd = ins[15:11]; 0: destination rt = ins[20:16].
- WB_link  in  1  destination forced to $31; data = pc_4.
- WB_pc_4  in  PC_W  PC+4 of the WB instruction.
- WB_ins  in  32  WB instruction word.
- WB_alu_res  in  32  ALU result / effective address.
- WB_mem_rdata  in  32  raw aligned word read from data memory.
- ID_rs_addr  in  5  read port A address.
- ID_rt_addr  in  5  read port B address.
- ID_rs_data  out  32  read port A data.
- ID_rt_data  out  32  read port B data.
- WB_wr_en  out  1  qualified write enable this cycle (for the forwarding unit).
- WB_wr_addr  out  5  resolved destination register.
- WB_wr_data  out  32  resolved write data.

Behaviour:
- Reset:
  - rst high clears all 32 registers to 0 immediately, without waiting for a clock edge.
  - A write in the same cycle as reset is discarded.
  - Since outputs derive from registers and WB inputs, ID_rs_data/ID_rt_data read 0 during reset (no bypass while rst is high).
  - WB_wr_en is 0 while rst is high.
- Destination (combinational):
  - WB_link=1 -> 31.
  - Else WB_regdst=1 -> ins[15:11].
  - Else -> ins[20:16].
- Write data priority (combinational):
  - WB_link -> {zero-extend, WB_pc_4}.
  - Else WB_memtoreg -> load_data.
  - Else WB_alu_res.
- load_data is formatted by opcode ins[31:26], using a = WB_alu_res[1:0] with little-endian lanes (byte k = bits 8k+7:8k):
  - 0x20 LB: sign-extend byte a.
  - 0x24 LBU: zero-extend byte a.
  - 0x21 LH: sign-extend halfword a[1]; a[0] ignored.
  - 0x25 LHU: zero-extend halfword a[1].
  - 0x23 LW and any other opcode: full word; a ignored.
- Write enable: WB_wr_en = WB_regwrite & (WB_wr_addr != 0) & !rst.
  - $0 is never written and always reads 0.
  - Bubble/NOP word 0x00000020 (add $0,$0,$0) therefore produces no write.
- Write timing: register updated at the rising clk edge when WB_wr_en=1; single write port; latency 1 edge.
- Read ports:
  - Combinational from the array.
  - If WB_wr_en=1 and the read address equals WB_wr_addr (non-zero), the port returns WB_wr_data in the same cycle (write-before-read bypass).
  - rs and rt reading the same address both receive identical data.
  - Address 0 always returns 0, including when a write targets the same address.
- No stall or flush inputs: WB always retires; upstream pipeline registers hold or bubble the inputs.
- Asynchronous rst assertion mid-write: the edge write is lost and the array is clear by the time rst deasserts; first write takes effect at the first clk edge after rst falls.

Test Plan:
- Reset: drive rst=1 with WB_regwrite=1, rd=5 -> all reads return 0, WB_wr_en=0; release rst, read $5 -> 0.
- ALU write + bypass: ins with rd=8, regdst=1, regwrite=1, alu_res=0x1234_5678; same cycle ID_rs_addr=8 -> ID_rs_data=0x12345678 before the edge; after the edge it still reads 0x12345678 with the write deasserted.
- Loads: mem_rdata=0x80FF_7F01 with alu_res[1:0]=3:
  - LB -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH (a[1]=1) -> 0xFFFF80FF.
  - LHU -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - Each written to rt=9 with regdst=0.
- Link: WB_link=1, regdst=0, pc_4=9'h1F4, memtoreg=1 -> $31 = 0x000001F4; link overrides both memtoreg and regdst.
- $0 protection: regwrite=1 with rd=0, alu_res=0xDEADBEEF, read port on $0 -> WB_wr_en=0, $0 reads 0; NOP 0x00000020 changes no register.
- Dual read: write $3=0xA5A5A5A5; then rs=rt=3 -> both ports 0xA5A5A5A5; a simultaneous write to $4 leaves the $3 reads unaffected.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32x32 architectural register file.
//
// Resolves the destination register and write data for the instruction leaving
// MEM/WB, formats load data by opcode, writes the register file on the rising
// clock edge and serves the two ID-stage read ports with same-cycle bypass.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   WB_memtoreg       write data comes from formatted memory read data
//   WB_regwrite       instruction writes a register
//   WB_regdst         1: dest = ins[15:11], 0: dest = ins[20:16]
//   WB_link           dest forced to $31, data = zero-extended WB_pc_4
//   WB_pc_4           PC+4 of the WB instruction
//   WB_ins            WB instruction word
//   WB_alu_res        ALU result / effective address
//   WB_mem_rdata      raw aligned word from data memory
//   ID_rs_addr/data   read port A
//   ID_rt_addr/data   read port B
//   WB_wr_en          qualified write enable (for the forwarding unit)
//   WB_wr_addr        resolved destination register
//   WB_wr_data        resolved write data
module wb_regfile #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned REG_N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_memtoreg,
  input  logic            WB_regwrite,
  input  logic            WB_regdst,
  input  logic            WB_link,
  input  logic [PC_W-1:0] WB_pc_4,
  input  logic [31:0]     WB_ins,
  input  logic [31:0]     WB_alu_res,
  input  logic [31:0]     WB_mem_rdata,
  input  logic [4:0]      ID_rs_addr,
  input  logic [4:0]      ID_rt_addr,
  output logic [31:0]     ID_rs_data,
  output logic [31:0]     ID_rt_data,
  output logic            WB_wr_en,
  output logic [4:0]      WB_wr_addr,
  output logic [31:0]     WB_wr_data
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;

  logic [31:0] regs_q [REG_N];

  logic [5:0]  opcode;
  logic [1:0]  byte_off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign opcode   = WB_ins[31:26];
  assign byte_off = WB_alu_res[1:0];

  // Little-endian lanes: byte k lives in bits 8k+7:8k.
  always_comb begin
    load_byte = WB_mem_rdata[7:0];
    unique case (byte_off)
      2'd0: load_byte = WB_mem_rdata[7:0];
      2'd1: load_byte = WB_mem_rdata[15:8];
      2'd2: load_byte = WB_mem_rdata[23:16];
      2'd3: load_byte = WB_mem_rdata[31:24];
      default: load_byte = WB_mem_rdata[7:0];
    endcase
  end

  // Halfword select uses only the upper offset bit; the low bit is ignored.
  assign load_half = byte_off[1] ? WB_mem_rdata[31:16] : WB_mem_rdata[15:0];

  always_comb begin
    load_data = WB_mem_rdata;
    case (opcode)
      OpLb:    load_data = {{24{load_byte[7]}}, load_byte};
      OpLbu:   load_data = {24'd0, load_byte};
      OpLh:    load_data = {{16{load_half[15]}}, load_half};
      OpLhu:   load_data = {16'd0, load_half};
      default: load_data = WB_mem_rdata;
    endcase
  end

  // Destination select: link beats regdst.
  always_comb begin
    WB_wr_addr = WB_ins[20:16];
    if (WB_link) begin
      WB_wr_addr = 5'd31;
    end else if (WB_regdst) begin
      WB_wr_addr = WB_ins[15:11];
    end
  end

  // Write data select: link beats memtoreg.
  always_comb begin
    WB_wr_data = WB_alu_res;
    if (WB_link) begin
      WB_wr_data = {{(32 - PC_W){1'b0}}, WB_pc_4};
    end else if (WB_memtoreg) begin
      WB_wr_data = load_data;
    end
  end

  // $0 is never written, so the NOP bubble (add $0,$0,$0) retires silently.
  assign WB_wr_en = WB_regwrite & (WB_wr_addr != 5'd0) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WB_wr_en) begin
      regs_q[WB_wr_addr] <= WB_wr_data;
    end
  end

  // Read ports: $0 hard-wired to zero, then write-before-read bypass, then array.
  always_comb begin
    ID_rs_data = regs_q[ID_rs_addr];
    if (ID_rs_addr == 5'd0) begin
      ID_rs_data = '0;
    end else if (WB_wr_en && (ID_rs_addr == WB_wr_addr)) begin
      ID_rs_data = WB_wr_data;
    end
  end

  always_comb begin
    ID_rt_data = regs_q[ID_rt_addr];
    if (ID_rt_addr == 5'd0) begin
      ID_rt_data = '0;
    end else if (WB_wr_en && (ID_rt_addr == WB_wr_addr)) begin
      ID_rt_data = WB_wr_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        WB_memtoreg;
  logic        WB_regwrite;
  logic        WB_regdst;
  logic        WB_link;
  logic [8:0]  WB_pc_4;
  logic [31:0] WB_ins;
  logic [31:0] WB_alu_res;
  logic [31:0] WB_mem_rdata;
  logic [4:0]  ID_rs_addr;
  logic [4:0]  ID_rt_addr;
  logic [31:0] ID_rs_data;
  logic [31:0] ID_rt_data;
  logic        WB_wr_en;
  logic [4:0]  WB_wr_addr;
  logic [31:0] WB_wr_data;

  wb_regfile #(
    .PC_W (9),
    .REG_N(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WB_memtoreg (WB_memtoreg),
    .WB_regwrite (WB_regwrite),
    .WB_regdst   (WB_regdst),
    .WB_link     (WB_link),
    .WB_pc_4     (WB_pc_4),
    .WB_ins      (WB_ins),
    .WB_alu_res  (WB_alu_res),
    .WB_mem_rdata(WB_mem_rdata),
    .ID_rs_addr  (ID_rs_addr),
    .ID_rt_addr  (ID_rt_addr),
    .ID_rs_data  (ID_rs_data),
    .ID_rt_data  (ID_rt_data),
    .WB_wr_en    (WB_wr_en),
    .WB_wr_addr  (WB_wr_addr),
    .WB_wr_data  (WB_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output selectors for scoreboard entries.
  localparam int SelRs   = 0;
  localparam int SelRt   = 1;
  localparam int SelWen  = 2;
  localparam int SelWadr = 3;
  localparam int SelWdat = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] mk_ins(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {op, 5'd0, rt, rd, 11'd0};
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic link, input logic memtoreg, input logic regwrite,
                       input logic regdst, input logic [8:0] pc4, input logic [31:0] ins,
                       input logic [31:0] alu, input logic [31:0] mem);
    WB_link      = link;
    WB_memtoreg  = memtoreg;
    WB_regwrite  = regwrite;
    WB_regdst    = regdst;
    WB_pc_4      = pc4;
    WB_ins       = ins;
    WB_alu_res   = alu;
    WB_mem_rdata = mem;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic reads(input logic [4:0] rs, input logic [4:0] rt);
    ID_rs_addr = rs;
    ID_rt_addr = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare all pending expectations mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        SelRs:   act = ID_rs_data;
        SelRt:   act = ID_rt_data;
        SelWen:  act = {31'd0, WB_wr_en};
        SelWadr: act = {27'd0, WB_wr_addr};
        default: act = WB_wr_data;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  localparam logic [31:0] MemWord = 32'h80FF_7F01;

  logic [5:0]  ld_op  [7];
  logic [31:0] ld_alu [7];
  logic [31:0] ld_exp [7];
  string       ld_nm  [7];

  initial begin
    ld_op[0] = 6'h20; ld_alu[0] = 32'h0000_1003; ld_exp[0] = 32'hFFFF_FF80; ld_nm[0] = "lb_a3";
    ld_op[1] = 6'h24; ld_alu[1] = 32'h0000_1003; ld_exp[1] = 32'h0000_0080; ld_nm[1] = "lbu_a3";
    ld_op[2] = 6'h21; ld_alu[2] = 32'h0000_1003; ld_exp[2] = 32'hFFFF_80FF; ld_nm[2] = "lh_a3";
    ld_op[3] = 6'h25; ld_alu[3] = 32'h0000_1003; ld_exp[3] = 32'h0000_80FF; ld_nm[3] = "lhu_a3";
    ld_op[4] = 6'h20; ld_alu[4] = 32'h0000_1000; ld_exp[4] = 32'h0000_0001; ld_nm[4] = "lb_a0";
    ld_op[5] = 6'h21; ld_alu[5] = 32'h0000_1001; ld_exp[5] = 32'h0000_7F01; ld_nm[5] = "lh_a1";
    ld_op[6] = 6'h23; ld_alu[6] = 32'h0000_1003; ld_exp[6] = 32'h80FF_7F01; ld_nm[6] = "lw_a3";

    // Reset with a write presented: discarded, reads zero.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd0, 5'd5), 32'h0000_0055, 32'd0);
    reads(5'd5, 5'd5);
    push("rst_rs5", SelRs, 32'd0);
    push("rst_rt5", SelRt, 32'd0);
    push("rst_wen", SelWen, 32'd0);
    next_cycle();
    push("rst_edge_rs5", SelRs, 32'd0);
    push("rst_edge_wen", SelWen, 32'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    push("post_rst_rs5", SelRs, 32'd0);
    push("post_rst_wen", SelWen, 32'd0);

    // ALU write with same-cycle bypass.
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd2, 5'd8), 32'h1234_5678, 32'd0);
    reads(5'd8, 5'd2);
    push("alu_bypass_rs", SelRs, 32'h1234_5678);
    push("alu_wen", SelWen, 32'd1);
    push("alu_waddr", SelWadr, 32'd8);
    push("alu_wdata", SelWdat, 32'h1234_5678);
    push("alu_rt_other", SelRt, 32'd0);
    next_cycle();
    idle();
    push("alu_stored_rs", SelRs, 32'h1234_5678);
    push("alu_idle_wen", SelWen, 32'd0);

    // Loads into rt=9 (rd field holds 7 to show regdst=0 picks rt).
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, mk_ins(ld_op[i], 5'd9, 5'd7), ld_alu[i], MemWord);
      reads(5'd7, 5'd9);
      push({ld_nm[i], "_wdata"}, SelWdat, ld_exp[i]);
      push({ld_nm[i], "_waddr"}, SelWadr, 32'd9);
      push({ld_nm[i], "_bypass"}, SelRt, ld_exp[i]);
      push({ld_nm[i], "_rd7"}, SelRs, 32'd0);
      next_cycle();
      idle();
      push({ld_nm[i], "_stored"}, SelRt, ld_exp[i]);
    end

    // Link overrides memtoreg and regdst.
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 9'h1F4, mk_ins(6'h23, 5'd9, 5'd8), 32'h0000_1003, MemWord);
    reads(5'd31, 5'd9);
    push("link_waddr", SelWadr, 32'd31);
    push("link_wdata", SelWdat, 32'h0000_01F4);
    push("link_bypass", SelRs, 32'h0000_01F4);
    push("link_rt9_kept", SelRt, 32'h80FF_7F01);
    next_cycle();
    idle();
    reads(5'd31, 5'd8);
    push("link_stored", SelRs, 32'h0000_01F4);
    push("link_r8_kept", SelRt, 32'h1234_5678);

    // $0 protection and NOP bubble.
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd0, 5'd0), 32'hDEAD_BEEF, 32'd0);
    reads(5'd0, 5'd0);
    push("r0_wen", SelWen, 32'd0);
    push("r0_rs", SelRs, 32'd0);
    push("r0_rt", SelRt, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 32'h0000_0020, 32'h0000_CAFE, 32'd0);
    reads(5'd0, 5'd8);
    push("nop_wen", SelWen, 32'd0);
    push("nop_rs0", SelRs, 32'd0);
    next_cycle();
    idle();
    reads(5'd8, 5'd9);
    push("nop_r8_kept", SelRs, 32'h1234_5678);
    push("nop_r9_kept", SelRt, 32'h80FF_7F01);

    // Dual read of $3 while writing $4.
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd0, 5'd3), 32'hA5A5_A5A5, 32'd0);
    reads(5'd1, 5'd1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd0, 5'd4), 32'h4444_4444, 32'd0);
    reads(5'd3, 5'd3);
    push("dual_rs3", SelRs, 32'hA5A5_A5A5);
    push("dual_rt3", SelRt, 32'hA5A5_A5A5);
    push("dual_waddr4", SelWadr, 32'd4);
    next_cycle();
    idle();
    reads(5'd4, 5'd3);
    push("dual_r4_stored", SelRs, 32'h4444_4444);
    push("dual_r3_kept", SelRt, 32'hA5A5_A5A5);

    // Asynchronous reset mid-write: array clears, pending write lost.
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, mk_ins(6'h00, 5'd0, 5'd10), 32'h0000_0077, 32'd0);
    reads(5'd8, 5'd10);
    #2;
    rst = 1'b1;
    push("arst_r8", SelRs, 32'd0);
    push("arst_r10", SelRt, 32'd0);
    push("arst_wen", SelWen, 32'd0);
    next_cycle();
    rst = 1'b0;
    push("arst_release_bypass", SelRt, 32'h0000_0077);
    push("arst_release_wen", SelWen, 32'd1);
    push("arst_release_r8", SelRs, 32'd0);
    next_cycle();
    idle();
    push("arst_first_write", SelRt, 32'h0000_0077);
    push("arst_r8_still0", SelRs, 32'd0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
